// File: rtl/bus_map_pkg.sv
// Shared address map defaults, status-word bit positions and read FSM states
// for the data-side bus controller.
package bus_map_pkg;

    localparam int RAM_BASE_DEF     = 256;
    localparam int RAM_SIZE_DEF     = 256;
    localparam int LED_ADDR_DEF     = 1024;
    localparam int UART_TX_ADDR_DEF = 1028;
    localparam int UART_RX_ADDR_DEF = 1032;
    localparam int STATUS_ADDR_DEF  = 1036;
    localparam int TX_DEPTH_DEF     = 4;
    localparam int TIMEOUT_DEF      = 15;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_RX_VALID     = 2;
    localparam int ST_TX_OVF       = 3;
    localparam int ST_RAM_TIMEOUT  = 4;
    localparam int ST_UNMAPPED_ERR = 5;
    localparam int ST_COUNT_LSB    = 8;

    typedef enum logic [1:0] {
        IDLE,
        RAM_WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head output; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count decide
    // validity, and a reset-free array maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Data-side bus controller: address decode, read handshake FSM, UART TX FIFO,
// LED register and W1C status/error register.
module mem_bus_ctrl
    import bus_map_pkg::*;
#(
    parameter int RAM_BASE     = RAM_BASE_DEF,
    parameter int RAM_SIZE     = RAM_SIZE_DEF,
    parameter int LED_ADDR     = LED_ADDR_DEF,
    parameter int UART_TX_ADDR = UART_TX_ADDR_DEF,
    parameter int UART_RX_ADDR = UART_RX_ADDR_DEF,
    parameter int STATUS_ADDR  = STATUS_ADDR_DEF,
    parameter int TX_DEPTH     = TX_DEPTH_DEF,
    parameter int TIMEOUT      = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] data_out,
    input  logic        mem,
    input  logic        mem_write,
    output logic [31:0] data_in,
    output logic        read_ack,
    output logic        ram_mem_read,
    output logic        ram_mem_write,
    input  logic        ram_read_ack,
    input  logic [31:0] ram_out,
    output logic [31:0] led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop
);

    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [31:0] RAM_LO = 32'(RAM_BASE);
    localparam logic [31:0] RAM_HI = 32'(RAM_BASE + RAM_SIZE);

    state_t          state, next_state;
    logic [WW-1:0]   wait_cnt;
    logic            ram_sel, led_sel, tx_sel, rx_sel, status_sel, any_sel;
    logic            wr_req, status_wr, unmapped_wr;
    logic            rd_load, set_timeout, set_unmapped_rd;
    logic [31:0]     rd_value, status_word;
    logic            tx_push, tx_pop, tx_full, tx_empty;
    logic [CW-1:0]   tx_count;
    logic            tx_ovf, ram_timeout, unmapped_err;

    always_comb begin
        ram_sel    = (addr >= RAM_LO) && (addr < RAM_HI);
        led_sel    = (addr == 32'(LED_ADDR));
        tx_sel     = (addr == 32'(UART_TX_ADDR));
        rx_sel     = (addr == 32'(UART_RX_ADDR));
        status_sel = (addr == 32'(STATUS_ADDR));
        any_sel    = ram_sel || led_sel || tx_sel || rx_sel || status_sel;
    end

    assign wr_req        = (state == IDLE) && mem && mem_write;
    assign ram_mem_write = wr_req && ram_sel;
    assign status_wr     = wr_req && status_sel;
    assign unmapped_wr   = wr_req && !any_sel;
    assign tx_push       = wr_req && tx_sel;
    assign tx_pop        = tx_valid && tx_ready;
    assign tx_valid      = !tx_empty;

    always_comb begin
        status_word                         = '0;
        status_word[ST_TX_FULL]             = tx_full;
        status_word[ST_TX_EMPTY]            = tx_empty;
        status_word[ST_RX_VALID]            = rx_valid;
        status_word[ST_TX_OVF]              = tx_ovf;
        status_word[ST_RAM_TIMEOUT]         = ram_timeout;
        status_word[ST_UNMAPPED_ERR]        = unmapped_err;
        status_word[ST_COUNT_LSB +: CW]     = tx_count;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state      = state;
        rd_load         = 1'b0;
        rd_value        = '0;
        set_timeout     = 1'b0;
        set_unmapped_rd = 1'b0;
        ram_mem_read    = 1'b0;
        read_ack        = 1'b0;
        rx_pop          = 1'b0;
        case (state)
            IDLE: begin
                if (mem && !mem_write) begin
                    if (ram_sel) begin
                        next_state = RAM_WAIT;
                    end else begin
                        rd_load    = 1'b1;
                        next_state = RESP;
                        if (led_sel)         rd_value = led;
                        else if (status_sel) rd_value = status_word;
                        else if (rx_sel) begin
                            if (rx_valid) rd_value = {24'b0, rx_data};
                            rx_pop = rx_valid;
                        end else if (!tx_sel) set_unmapped_rd = 1'b1;
                    end
                end
            end
            RAM_WAIT: begin
                ram_mem_read = 1'b1;
                if (ram_read_ack) begin
                    rd_load    = 1'b1;
                    rd_value   = ram_out;
                    next_state = RESP;
                end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                    rd_load     = 1'b1;
                    rd_value    = 32'hFFFF_FFFF;
                    set_timeout = 1'b1;
                    next_state  = RESP;
                end
            end
            RESP: begin
                read_ack   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt     <= '0;
            data_in      <= '0;
            led          <= '0;
            tx_ovf       <= 1'b0;
            ram_timeout  <= 1'b0;
            unmapped_err <= 1'b0;
        end else begin
            wait_cnt <= (state == RAM_WAIT) ? wait_cnt + 1'b1 : '0;
            if (rd_load) data_in <= rd_value;
            if (wr_req && led_sel) led <= data_out;
            // Status flags are sticky; software clears them by writing 1s.
            if (tx_push && tx_full && !tx_pop)              tx_ovf <= 1'b1;
            else if (status_wr && data_out[ST_TX_OVF])      tx_ovf <= 1'b0;
            if (set_timeout)                                ram_timeout <= 1'b1;
            else if (status_wr && data_out[ST_RAM_TIMEOUT]) ram_timeout <= 1'b0;
            if (unmapped_wr || set_unmapped_rd)              unmapped_err <= 1'b1;
            else if (status_wr && data_out[ST_UNMAPPED_ERR]) unmapped_err <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .wdata (data_out[7:0]),
        .pop   (tx_pop),
        .rdata (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: LED, RAM handshake/timeout, TX FIFO overflow,
// RX pop, unmapped errors, window edges and reset during a RAM wait.
module tb_mem_bus_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, data_out, data_in, ram_out, led;
    logic        mem, mem_write, read_ack, ram_mem_read, ram_mem_write, ram_read_ack;
    logic [7:0]  tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_pop;

    int total = 0;
    int bad   = 0;

    logic [31:0] rd_data;
    int          rd_cycles, rd_rmr, rd_pops;
    logic        last_ram_wr;
    logic [7:0]  got [8];
    int          n_got;
    int          ack_seen;

    always #5 clk = ~clk;

    mem_bus_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .data_out      (data_out),
        .mem           (mem),
        .mem_write     (mem_write),
        .data_in       (data_in),
        .read_ack      (read_ack),
        .ram_mem_read  (ram_mem_read),
        .ram_mem_write (ram_mem_write),
        .ram_read_ack  (ram_read_ack),
        .ram_out       (ram_out),
        .led           (led),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_pop        (rx_pop)
    );

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got_v, exp_v);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; data_out = d; mem = 1'b1; mem_write = 1'b1;
        #1 last_ram_wr = ram_mem_write;
        @(posedge clk); #1;
        mem = 1'b0; mem_write = 1'b0;
    endtask

    // ack_after: number of edges after the request before ram_read_ack rises (0 = never)
    task automatic bus_read(input logic [31:0] a, input int ack_after, input logic [31:0] ram_val);
        int   i = 0;
        logic acked = 1'b0;
        addr = a; mem = 1'b1; mem_write = 1'b0;
        rd_rmr = 0; rd_pops = 0; rd_cycles = 0; rd_data = 'x;
        while (!acked && i < 40) begin
            #1;
            if (ram_mem_read) rd_rmr++;
            if (rx_pop)       rd_pops++;
            @(posedge clk); #1;
            i++;
            if (read_ack) begin
                acked = 1'b1;
                rd_data = data_in;
                rd_cycles = i;
            end else if (ack_after != 0 && i == ack_after) begin
                ram_read_ack = 1'b1; ram_out = ram_val;
            end else begin
                ram_read_ack = 1'b0;
            end
        end
        check("read_ack_seen", 32'(acked), 32'd1);
        mem = 1'b0; ram_read_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain_tx();
        n_got = 0;
        tx_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (tx_valid && n_got < 8) begin
                got[n_got] = tx_data;
                n_got++;
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = '0; data_out = '0; mem = 1'b0; mem_write = 1'b0;
        ram_read_ack = 1'b0; ram_out = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_led", led, 32'h0);
        check("rst_data_in", data_in, 32'h0);
        check("rst_read_ack", 32'(read_ack), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_ram_rd", 32'(ram_mem_read), 32'd0);
        check("rst_status", {30'b0, rx_pop, ram_mem_write}, 32'h0);

        // LED write then read back
        bus_write(32'd1024, 32'h0000_00A5);
        check("led_write", led, 32'h0000_00A5);
        check("led_no_ram_wr", 32'(last_ram_wr), 32'd0);
        bus_read(32'd1024, 0, '0);
        check("led_read_data", rd_data, 32'h0000_00A5);
        check("led_read_lat", 32'(rd_cycles), 32'd1);

        // RAM write strobe and RAM read with late ack
        bus_write(32'd300, 32'h1111_2222);
        check("ram_wr_strobe", 32'(last_ram_wr), 32'd1);
        bus_read(32'd260, 3, 32'h0000_1234);
        check("ram_read_data", rd_data, 32'h0000_1234);
        check("ram_read_lat", 32'(rd_cycles), 32'd4);
        check("ram_read_strobe", 32'(rd_rmr), 32'd3);

        // RAM timeout and W1C of its flag
        bus_read(32'd260, 0, '0);
        check("tmo_data", rd_data, 32'hFFFF_FFFF);
        check("tmo_lat", 32'(rd_cycles), 32'd16);
        check("tmo_strobe", 32'(rd_rmr), 32'd15);
        bus_read(32'd1036, 0, '0);
        check("tmo_status", rd_data, 32'h0000_0012);
        bus_write(32'd1036, 32'h0000_0010);
        bus_read(32'd1036, 0, '0);
        check("tmo_cleared", rd_data, 32'h0000_0002);

        // TX overflow: fifth byte dropped
        for (int k = 0; k < 5; k++) bus_write(32'd1028, 32'(8'h61 + k));
        bus_read(32'd1036, 0, '0);
        check("tx_full_status", rd_data, 32'h0000_0409);
        check("tx_head", 32'(tx_data), 32'h61);
        drain_tx();
        check("tx_drain_count", 32'(n_got), 32'd4);
        for (int k = 0; k < 4; k++) check("tx_byte", 32'(got[k]), 32'(8'h61 + k));
        bus_read(32'd1036, 0, '0);
        check("tx_empty_status", rd_data, 32'h0000_000A);
        bus_write(32'd1036, 32'h0000_0008);

        // Push into a full FIFO with a simultaneous pop is accepted
        for (int k = 0; k < 4; k++) bus_write(32'd1028, 32'(8'h66 + k));
        tx_ready = 1'b1;
        bus_write(32'd1028, 32'h0000_006A);
        tx_ready = 1'b0;
        bus_read(32'd1036, 0, '0);
        check("tx_push_pop_status", rd_data, 32'h0000_0401);
        drain_tx();
        check("tx_pp_count", 32'(n_got), 32'd4);
        for (int k = 0; k < 4; k++) check("tx_pp_byte", 32'(got[k]), 32'(8'h67 + k));

        // RX read with and without a byte waiting
        rx_valid = 1'b1; rx_data = 8'h62;
        bus_read(32'd1032, 0, '0);
        check("rx_data", rd_data, 32'h0000_0062);
        check("rx_pop_once", 32'(rd_pops), 32'd1);
        rx_valid = 1'b0; rx_data = 8'h77;
        bus_read(32'd1032, 0, '0);
        check("rx_empty_data", rd_data, 32'h0);
        check("rx_empty_pop", 32'(rd_pops), 32'd0);

        // Unmapped read and write
        bus_read(32'd1024, 0, '0);
        bus_read(32'd2000, 0, '0);
        check("unm_rd_data", rd_data, 32'h0);
        bus_read(32'd1036, 0, '0);
        check("unm_rd_status", rd_data, 32'h0000_0022);
        bus_write(32'd1036, 32'h0000_0020);
        bus_write(32'h4000_0000, 32'hDEAD_BEEF);
        check("unm_wr_led", led, 32'h0000_00A5);
        bus_read(32'd1036, 0, '0);
        check("unm_wr_status", rd_data, 32'h0000_0022);
        bus_write(32'd1036, 32'h0000_0020);

        // RAM window edges
        bus_read(32'd511, 1, 32'hCAFE_0001);
        check("ram_top_data", rd_data, 32'hCAFE_0001);
        check("ram_top_lat", 32'(rd_cycles), 32'd2);
        check("ram_top_strobe", 32'(rd_rmr), 32'd1);
        bus_read(32'd255, 0, '0);
        check("below_ram_strobe", 32'(rd_rmr), 32'd0);
        bus_read(32'd512, 0, '0);
        check("above_ram_strobe", 32'(rd_rmr), 32'd0);
        bus_read(32'd1036, 0, '0);
        check("edge_status", rd_data, 32'h0000_0022);

        // Reset during RAM_WAIT
        bus_write(32'd1028, 32'h0000_007A);
        addr = 32'd260; mem = 1'b1; mem_write = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("pre_rst_strobe", 32'(ram_mem_read), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_strobe", 32'(ram_mem_read), 32'd0);
        check("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_mid_led", led, 32'h0);
        mem = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        ack_seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (read_ack) ack_seen++;
        end
        check("rst_mid_no_ack", 32'(ack_seen), 32'd0);
        check("rst_mid_data_in", data_in, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
